// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - request, CSR-file port and redirect bundle for trap_ctrl; TRAP_CTRL_IRQ_EN adds irq lines
interface trap_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        busy;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef TRAP_CTRL_IRQ_EN
  logic        irq_pending;
  logic [31:0] irq_pc;
`endif

  modport slave (
`ifdef TRAP_CTRL_IRQ_EN
    input  irq_pending, irq_pc,
`endif
    input  req_valid, req_kind, req_pc, csr_rdata,
    output req_ready, busy, csr_addr, csr_we, csr_wdata, redirect_valid, redirect_pc
  );

  modport master (
`ifdef TRAP_CTRL_IRQ_EN
    output irq_pending, irq_pc,
`endif
    output req_valid, req_kind, req_pc, csr_rdata,
    input  req_ready, busy, csr_addr, csr_we, csr_wdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / mret sequencer driving a CSR-file port
// Optional interrupt entry enabled by defining TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE  = 32'h0000000b,
  parameter logic [31:0] EBREAK_CAUSE = 32'h00000003
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);
  localparam logic [11:0] MSTATUS   = 12'h300;
  localparam logic [11:0] MTVEC     = 12'h305;
  localparam logic [11:0] MEPC      = 12'h341;
  localparam logic [11:0] MCAUSE    = 12'h342;
  localparam logic [31:0] IRQ_CAUSE = 32'h80000007;

  typedef enum logic [2:0] {IDLE, EPC, CAUSE, STAT, VEC, RSTAT, RET} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d, cause_q, cause_d;
  logic        req_ready, busy, csr_we, redirect_valid;
  logic [11:0] csr_addr, idle_addr;
  logic [31:0] csr_wdata, redirect_pc, irq_pc;
  logic        irq_take;

  // With interrupts enabled, IDLE keeps mstatus on the CSR port so MIE is sampled every cycle.
`ifdef TRAP_CTRL_IRQ_EN
  assign idle_addr = MSTATUS;
  assign irq_take  = bus.irq_pending && bus.csr_rdata[3];
  assign irq_pc    = bus.irq_pc;
`else
  assign idle_addr = 12'h000;
  assign irq_take  = 1'b0;
  assign irq_pc    = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= 32'h0;
      cause_q <= 32'h0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d        = state;
    pc_d           = pc_q;
    cause_d        = cause_q;
    req_ready      = 1'b0;
    busy           = 1'b0;
    csr_addr       = 12'h000;
    csr_we         = 1'b0;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if (!rst) begin
      case (state)
        IDLE: begin
          csr_addr = idle_addr;
          if (irq_take) begin
            pc_d    = irq_pc;
            cause_d = IRQ_CAUSE;
            state_d = EPC;
          end else begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
              pc_d = bus.req_pc;
              case (bus.req_kind)
                2'b00: begin
                  cause_d = ECALL_CAUSE;
                  state_d = EPC;
                end
                2'b01: begin
                  cause_d = EBREAK_CAUSE;
                  state_d = EPC;
                end
                2'b10:   state_d = RSTAT;
                default: state_d = IDLE;
              endcase
            end
          end
        end
        EPC: begin
          busy      = 1'b1;
          csr_addr  = MEPC;
          csr_we    = 1'b1;
          csr_wdata = pc_q;
          state_d   = CAUSE;
        end
        CAUSE: begin
          busy      = 1'b1;
          csr_addr  = MCAUSE;
          csr_we    = 1'b1;
          csr_wdata = cause_q;
          state_d   = STAT;
        end
        STAT: begin
          busy      = 1'b1;
          csr_addr  = MSTATUS;
          csr_we    = 1'b1;
          // MPP=M, MPIE<=MIE, MIE<=0
          csr_wdata = {bus.csr_rdata[31:13], 2'b11, bus.csr_rdata[10:8], bus.csr_rdata[3],
                       bus.csr_rdata[6:4], 1'b0, bus.csr_rdata[2:0]};
          state_d   = VEC;
        end
        VEC: begin
          busy           = 1'b1;
          csr_addr       = MTVEC;
          redirect_valid = 1'b1;
          redirect_pc    = {bus.csr_rdata[31:2], 2'b00};
          state_d        = IDLE;
        end
        RSTAT: begin
          busy      = 1'b1;
          csr_addr  = MSTATUS;
          csr_we    = 1'b1;
          // MPP stays M, MIE<=MPIE, MPIE<=1
          csr_wdata = {bus.csr_rdata[31:13], 2'b11, bus.csr_rdata[10:8], 1'b1,
                       bus.csr_rdata[6:4], bus.csr_rdata[7], bus.csr_rdata[2:0]};
          state_d   = RET;
        end
        RET: begin
          busy           = 1'b1;
          csr_addr       = MEPC;
          redirect_valid = 1'b1;
          redirect_pc    = {bus.csr_rdata[31:2], 2'b00};
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.busy           = busy;
  assign bus.csr_addr       = csr_addr;
  assign bus.csr_we         = csr_we;
  assign bus.csr_wdata      = csr_wdata;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized scoreboard bench for trap_ctrl against a behavioural trap/CSR model
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   free_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trap_ctrl_if bus ();
  trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef TRAP_CTRL_IRQ_EN
  localparam logic [11:0] IDLE_ADDR = 12'h300;
`else
  localparam logic [11:0] IDLE_ADDR = 12'h000;
`endif

  // CSR file the controller talks to
  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = 12'h0;
  logic [31:0] poke_data = 32'h0;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  assign wr_addr = bus.csr_we ? bus.csr_addr : poke_addr;
  assign wr_data = bus.csr_we ? bus.csr_wdata : poke_data;

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = csr_mstatus;
      12'h305: bus.csr_rdata = csr_mtvec;
      12'h341: bus.csr_rdata = csr_mepc;
      12'h342: bus.csr_rdata = csr_mcause;
      default: bus.csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_we || poke_en) begin
      case (wr_addr)
        12'h300: csr_mstatus <= wr_data;
        12'h305: csr_mtvec   <= wr_data;
        12'h341: csr_mepc    <= wr_data;
        12'h342: csr_mcause  <= wr_data;
        default: ;
      endcase
    end
  end

  // Reference architectural state and expected output events {we, redirect, addr, data, cycle}
  logic [31:0] ref_mstatus, ref_mtvec, ref_mepc, ref_mcause;
  logic [61:0] exp_q[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [61:0] ev(input bit we, input bit rv, input logic [11:0] a,
                                     input logic [31:0] d, input int c);
    logic [15:0] c16;
    c16 = c[15:0];
    return {we, rv, a, d, c16};
  endfunction

  function automatic void model_trap(input logic [31:0] pc, input logic [31:0] cause, input int k);
    logic [31:0] ms;
    ms = (ref_mstatus & ~32'h00001888) | ((ref_mstatus & 32'h8) << 4) | 32'h00001800;
    exp_q.push_back(ev(1'b1, 1'b0, 12'h341, pc, k));
    exp_q.push_back(ev(1'b1, 1'b0, 12'h342, cause, k + 1));
    exp_q.push_back(ev(1'b1, 1'b0, 12'h300, ms, k + 2));
    exp_q.push_back(ev(1'b0, 1'b1, 12'h305, ref_mtvec & ~32'h3, k + 3));
    ref_mepc    = pc;
    ref_mcause  = cause;
    ref_mstatus = ms;
    free_cyc    = k + 4;
  endfunction

  function automatic void model_mret(input int k);
    logic [31:0] ms;
    ms = (ref_mstatus & ~32'h00001888) | ((ref_mstatus >> 4) & 32'h8) | 32'h00001880;
    exp_q.push_back(ev(1'b1, 1'b0, 12'h300, ms, k));
    exp_q.push_back(ev(1'b0, 1'b1, 12'h341, ref_mepc & ~32'h3, k + 1));
    ref_mstatus = ms;
    free_cyc    = k + 2;
  endfunction

  // Monitor: every write or redirect the DUT presents must match the head of the queue
  logic        prev_redir = 1'b0;
  logic [61:0] act_ev, exp_ev;
  always @(negedge clk) begin
    if (rst) begin
      prev_redir = 1'b0;
    end else begin
      if (bus.redirect_valid)
        chk(!prev_redir, "redirect_one_cycle", 64'(prev_redir), 64'(0));
      prev_redir = bus.redirect_valid;
      if (bus.csr_we || bus.redirect_valid) begin
        act_ev = {bus.csr_we, bus.redirect_valid, bus.csr_addr,
                  bus.redirect_valid ? bus.redirect_pc : bus.csr_wdata, cyc[15:0]};
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_event", 64'(act_ev), 64'(0));
        end else begin
          exp_ev = exp_q.pop_front();
          chk(act_ev == exp_ev, "event", 64'(act_ev), 64'(exp_ev));
        end
      end else if (!bus.busy) begin
        chk(bus.csr_addr == IDLE_ADDR && bus.csr_wdata == 32'h0 && bus.redirect_pc == 32'h0,
            "idle_outputs", 64'({bus.csr_addr, bus.csr_wdata}), 64'({IDLE_ADDR, 32'h0}));
      end
    end
  end

  task automatic wait_idle();
    while (cyc < free_cyc) @(negedge clk);
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    wait_idle();
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    case (a)
      12'h300: ref_mstatus = d;
      12'h305: ref_mtvec   = d;
      12'h341: ref_mepc    = d;
      12'h342: ref_mcause  = d;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [1:0] kind, input logic [31:0] pc);
    int t0, n, want, k;
    bus.req_valid = 1'b1; bus.req_kind = kind; bus.req_pc = pc;
    t0 = cyc;
    n  = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk(1'b0, "accept_timeout", 64'(cyc), 64'(free_cyc));
      bus.req_valid = 1'b0;
      return;
    end
    want = (t0 > free_cyc) ? t0 : free_cyc;
    chk(cyc == want, "accept_cycle", 64'(cyc), 64'(want));
    k = cyc + 1;
    case (kind)
      2'd0:    model_trap(pc, 32'h0000000b, k);
      2'd1:    model_trap(pc, 32'h00000003, k);
      2'd2:    model_mret(k);
      default: free_cyc = k;
    endcase
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_csrs(input string tag);
    chk(csr_mstatus == ref_mstatus, {tag, "_mstatus"}, 64'(csr_mstatus), 64'(ref_mstatus));
    chk(csr_mtvec   == ref_mtvec,   {tag, "_mtvec"},   64'(csr_mtvec),   64'(ref_mtvec));
    chk(csr_mepc    == ref_mepc,    {tag, "_mepc"},    64'(csr_mepc),    64'(ref_mepc));
    chk(csr_mcause  == ref_mcause,  {tag, "_mcause"},  64'(csr_mcause),  64'(ref_mcause));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved_ms, saved_mc, p, irq_pc_v;
    int r;
    bus.req_valid = 1'b0; bus.req_kind = 2'b00; bus.req_pc = 32'h0;
`ifdef TRAP_CTRL_IRQ_EN
    bus.irq_pending = 1'b0; bus.irq_pc = 32'h0;
`endif
    ref_mstatus = 0; ref_mtvec = 0; ref_mepc = 0; ref_mcause = 0;
    poke(12'h300, 32'h0); poke(12'h305, 32'h0); poke(12'h341, 32'h0); poke(12'h342, 32'h0);

    // Reset state
    #1;
    chk({bus.req_ready, bus.busy, bus.csr_we, bus.redirect_valid, bus.csr_addr} == 16'h0,
        "reset_ctrl", 64'({bus.req_ready, bus.busy, bus.csr_we, bus.redirect_valid, bus.csr_addr}), 64'(0));
    chk({bus.csr_wdata, bus.redirect_pc} == 64'h0, "reset_data", {bus.csr_wdata, bus.redirect_pc}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(bus.req_ready && !bus.busy, "ready_after_reset", 64'({bus.req_ready, bus.busy}), 64'(2));
    @(negedge clk);
    free_cyc = cyc;

    // Ecall with known values
    poke(12'h305, 32'h80001003);
    poke(12'h300, 32'h00000008);
    issue(2'd0, 32'h80000100);
    wait_idle();
    chk(csr_mepc == 32'h80000100, "ecall_mepc", 64'(csr_mepc), 64'(32'h80000100));
    chk(csr_mcause == 32'h0000000b, "ecall_mcause", 64'(csr_mcause), 64'(32'h0000000b));
    chk(csr_mstatus == 32'h00001880, "ecall_mstatus", 64'(csr_mstatus), 64'(32'h00001880));

    // Mret with known values
    poke(12'h341, 32'h80000104);
    issue(2'd2, 32'h12345678);
    wait_idle();
    chk(csr_mstatus == 32'h00001888, "mret_mstatus", 64'(csr_mstatus), 64'(32'h00001888));

    // Held request while busy, then reserved kind followed immediately by an ecall
    issue(2'd0, 32'h00000400);
    issue(2'd1, 32'h00000404);
    issue(2'd3, 32'h00000408);
    issue(2'd0, 32'h0000040c);
    wait_idle();
    check_csrs("busy_seq");

    // Reset while in CAUSE: mepc already committed, the rest abandoned
    saved_ms = ref_mstatus;
    saved_mc = ref_mcause;
    p = 32'h00000800;
    issue(2'd0, p);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk({bus.req_ready, bus.busy, bus.csr_we, bus.redirect_valid, bus.csr_addr} == 16'h0,
        "midreset_ctrl", 64'({bus.req_ready, bus.busy, bus.csr_we, bus.redirect_valid, bus.csr_addr}), 64'(0));
    chk({bus.csr_wdata, bus.redirect_pc} == 64'h0, "midreset_data", {bus.csr_wdata, bus.redirect_pc}, 64'(0));
    exp_q.delete();
    ref_mstatus = saved_ms;
    ref_mcause  = saved_mc;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(bus.req_ready == 1'b1, "ready_after_midreset", 64'(bus.req_ready), 64'(1));
    @(negedge clk);
    free_cyc = cyc;
    chk(csr_mstatus == saved_ms, "midreset_mstatus_kept", 64'(csr_mstatus), 64'(saved_ms));
    chk(csr_mepc == p, "midreset_mepc_committed", 64'(csr_mepc), 64'(p));
    issue(2'd0, 32'h00000900);
    wait_idle();
    check_csrs("post_reset");

`ifdef TRAP_CTRL_IRQ_EN
    // Interrupt wins over a simultaneous ecall while MIE=1; the ecall follows once MIE is cleared
    poke(12'h300, 32'h00000008);
    irq_pc_v = 32'h80002000;
    bus.irq_pc = irq_pc_v;
    bus.irq_pending = 1'b1;
    bus.req_valid = 1'b1; bus.req_kind = 2'd0; bus.req_pc = 32'h00000a00;
    model_trap(irq_pc_v, 32'h80000007, cyc + 1);
    #1;
    chk(bus.req_ready == 1'b0, "irq_ready_low", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    wait_idle();
    chk(csr_mcause == 32'h80000007, "irq_mcause", 64'(csr_mcause), 64'(32'h80000007));
    chk(csr_mepc == irq_pc_v, "irq_mepc", 64'(csr_mepc), 64'(irq_pc_v));
    issue(2'd0, 32'h00000a00);
    bus.irq_pending = 1'b0;
    wait_idle();
    check_csrs("irq");
`else
    irq_pc_v = 32'h0;
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) poke(12'h305, $urandom);
      if ($urandom_range(0, 3) == 0) poke(12'h300, $urandom);
      if ($urandom_range(0, 3) == 0) poke(12'h341, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 9);
      issue((r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3, $urandom);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'(0));
    check_csrs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter ECALL_CAUSE, default 32'h0000000b: mcause value written for an environment call.
REQ-002 Parameter EBREAK_CAUSE, default 32'h00000003: mcause value written for a breakpoint.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  trap/return request.
- req_kind  in  2  request kind: 00 ecall, 01 ebreak, 10 mret, 11 reserved.
- req_pc  in  32  pc of the requesting instruction.
- req_ready  out  1  high only in IDLE; the request is accepted on a clock edge where req_valid&&req_ready.
- busy  out  1  high in every state other than IDLE.
- csr_addr  out  12  CSR-file read/write address.
- csr_we  out  1  CSR-file write enable; the write commits at the clock edge.
- csr_wdata  out  32  CSR-file write data.
- csr_rdata  in  32  combinational CSR-file read data for csr_addr.
- redirect_valid  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  32  redirect target; valid only while redirect_valid is high.

Function
REQ-004 The FSM SHALL have the states IDLE, EPC, CAUSE, STAT, VEC, RSTAT and RET; all outputs SHALL be decoded from the state and the latched registers.
REQ-005 On acceptance the block SHALL latch req_pc into pc_q and select the next state by kind:
- ecall: cause_q=ECALL_CAUSE, next state EPC.
- ebreak: cause_q=EBREAK_CAUSE, next state EPC.
- mret: next state RSTAT.
- 11: the request is consumed, no CSR activity, and the state stays IDLE.
REQ-006 EPC state: csr_addr=12'h341, csr_we=1, csr_wdata=pc_q; next state CAUSE.
REQ-007 CAUSE state: csr_addr=12'h342, csr_we=1, csr_wdata=cause_q; next state STAT.
REQ-008 STAT state (read-modify-write of mstatus):
- csr_addr=12'h300 and csr_we=1.
- csr_wdata=csr_rdata with bit7 (MPIE)=csr_rdata[3], bit3 (MIE)=0, and bits[12:11] (MPP)=2'b11.
- Next state VEC.
REQ-009 VEC state: csr_addr=12'h305, csr_we=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}; next state IDLE.
REQ-010 RSTAT state:
- csr_addr=12'h300 and csr_we=1.
- csr_wdata=csr_rdata with bit3=csr_rdata[7], bit7=1, and bits[12:11]=2'b11.
- Next state RET.
REQ-011 RET state: csr_addr=12'h341, csr_we=0, redirect_valid=1, redirect_pc={csr_rdata[31:2],2'b00}; next state IDLE.
REQ-012 Latency: a trap accepted at edge T SHALL write in the cycles after T, T+1 and T+2, and SHALL pulse redirect in the cycle after T+3. An mret SHALL write in the cycle after T and pulse redirect in the cycle after T+1.
REQ-013 req_valid while busy SHALL be ignored and not queued; the requester holds the request until req_ready is high.
REQ-014 A new request SHALL be acceptable in the cycle immediately following the redirect pulse; there are no bubble cycles beyond IDLE.
REQ-015 In IDLE: csr_we=0, redirect_valid=0, csr_addr=12'h000, csr_wdata=0.
REQ-016 redirect_valid SHALL never be high for more than one consecutive cycle per request.

Reset
REQ-017 rst SHALL force state IDLE and clear pc_q and cause_q to 0 immediately, without waiting for a clock edge.
REQ-018 While rst is high: req_ready=0, busy=0, csr_we=0, redirect_valid=0, csr_addr=0, csr_wdata=0, redirect_pc=0.
REQ-019 A reset mid-sequence SHALL abandon the remaining writes; CSR writes already committed are not undone.
REQ-020 req_ready SHALL be 1 from the first clock cycle after rst deasserts.

Configuration
REQ-021 With TRAP_CTRL_IRQ_EN defined:
- Input irq_pending (1 bit) and input irq_pc (32 bits) are added.
- In IDLE, irq_pending && mstatus MIE high takes priority over req_valid.
- The MIE sample is read through csr_addr=12'h300 in IDLE.
- On taking the interrupt: cause_q=32'h80000007, pc_q=irq_pc, req_ready=0 that cycle, then the sequence EPC..VEC runs.
REQ-022 Without TRAP_CTRL_IRQ_EN those ports are absent and IDLE SHALL drive csr_addr=12'h000.

Verification
REQ-023 Ecall check:
- Stimulus: ecall with req_pc=32'h80000100, mtvec=32'h80001003, mstatus=32'h00000008.
- Required: mepc=32'h80000100, mcause=32'h0000000b, mstatus=32'h00001880, and a one-cycle redirect to 32'h80001000.
REQ-024 Mret check:
- Stimulus: mret with mepc=32'h80000104 and mstatus=32'h00001880.
- Required: mstatus=32'h00001888 and redirect 32'h80000104 two cycles after acceptance.
REQ-025 Busy/reserved check:
- Stimulus: req_valid held during busy, then a kind=11 request.
- Required: the held request is accepted only after the redirect; the kind=11 request yields no csr_we and no redirect.
REQ-026 Reset check:
- Stimulus: rst asserted in the CAUSE state.
- Required: all outputs 0 immediately, mstatus is unchanged, and a fresh ecall completes normally.
REQ-027 IRQ check (TRAP_CTRL_IRQ_EN defined):
- Stimulus: irq_pending and ecall simultaneously with MIE=1.
- Required: mcause=32'h80000007 and mepc=irq_pc.
- Also: with MIE=0 the ecall is taken.
